// File: rtl/tlul_data_integ_pipe.sv
// Per-lane inverted Hsiao (39,32) SECDED encode (Mode 0) or check/correct (Mode 1) feeding a
// small valid/ready output FIFO. Optional error-beat counter: TLUL_DATA_INTEG_ERR_CNT_EN.
module tlul_data_integ_pipe #(
  parameter int unsigned NumLanes = 1,
  parameter int unsigned Mode     = 0,
  parameter int unsigned Depth    = 2,
  localparam int unsigned InW     = (Mode == 0) ? 32 : 39,
  localparam int unsigned OutW    = (Mode == 0) ? 39 : 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [NumLanes*InW-1:0]  data_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [NumLanes*OutW-1:0] data_o,
  output logic [NumLanes*2-1:0]    err_o
`ifdef TLUL_DATA_INTEG_ERR_CNT_EN
  ,
  input  logic                     err_cnt_clr_i,
  output logic [15:0]              err_cnt_o
`endif
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  // Check bits are stored inverted so an all-zero word is never a valid codeword.
  localparam logic [38:0] InvMask = 39'h2A00000000;
  // Row i covers data bits [31:0] plus its own check bit 32+i.
  localparam logic [6:0][38:0] HMask = {
    39'h4098505586, 39'h202DCC624C, 39'h10C2C1323B, 39'h0831234ED1,
    39'h04413D89AA, 39'h02DEBA8050, 39'h012606BD25
  };

  function automatic logic [38:0] secded_enc(input logic [31:0] d);
    logic [38:0] w;
    w = {7'h00, d};
    for (int i = 0; i < 7; i++) begin
      w[32+i] = ^(d & HMask[i][31:0]);
    end
    return w ^ InvMask;
  endfunction

  // Returns {double_err, single_err, corrected_data}.
  function automatic logic [33:0] secded_dec(input logic [38:0] w);
    logic [38:0] x;
    logic [6:0]  s;
    logic [6:0]  col;
    logic [31:0] d;
    x = w ^ InvMask;
    for (int i = 0; i < 7; i++) begin
      s[i] = ^(x & HMask[i]);
    end
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 7; j++) begin
        col[j] = HMask[j][i];
      end
      d[i] = x[i] ^ (s == col);
    end
    return {(s != 7'h00) & ~(^s), ^s, d};
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  logic [NumLanes*OutW-1:0] code_d;
  logic [NumLanes*2-1:0]    lane_err;

  for (genvar k = 0; k < NumLanes; k++) begin : g_lane
    if (Mode == 0) begin : g_enc
      assign code_d[k*OutW +: OutW] = secded_enc(data_i[k*InW +: InW]);
      assign lane_err[2*k +: 2]     = 2'b00;
    end else begin : g_dec
      logic [33:0] dec;
      assign dec                    = secded_dec(data_i[k*InW +: InW]);
      assign code_d[k*OutW +: OutW] = dec[31:0];
      assign lane_err[2*k +: 2]     = dec[33:32];
    end
  end

  logic [NumLanes*OutW-1:0] mem_data_q [Depth];
  logic [NumLanes*2-1:0]    mem_err_q  [Depth];
  logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     push, pop;

  assign ready_o = (cnt_q < CntW'(Depth));
  assign valid_o = (cnt_q != '0);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;
  assign data_o  = mem_data_q[rd_ptr_q];
  assign err_o   = mem_err_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_data_q[i] <= '0;
        mem_err_q[i]  <= '0;
      end
    end else begin
      if (push) begin
        mem_data_q[wr_ptr_q] <= code_d;
        mem_err_q[wr_ptr_q]  <= lane_err;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      cnt_q <= cnt_d;
    end
  end

`ifdef TLUL_DATA_INTEG_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr_i) begin
      err_cnt_d = 16'h0000;
    end else if (push && (|lane_err) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'h0001;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= 16'h0000;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_tlul_data_integ_pipe.sv
// Scoreboard bench: a 1-lane encoder (Depth 1) and a 4-lane checker (Depth 2) driven with random
// and directed beats; expected beats come from a reference SECDED model and a per-DUT queue.
module tb_tlul_data_integ_pipe;

  typedef struct packed {
    logic [127:0] data;
    logic [7:0]   err;
  } exp_t;

  logic         clk, rst_ni;
  logic         e_valid, e_ready, e_vo, e_ri;
  logic [31:0]  e_din;
  logic [38:0]  e_dout;
  logic [1:0]   e_err;
  logic         d_valid, d_ready, d_vo, d_ri;
  logic [155:0] d_din;
  logic [127:0] d_dout;
  logic [7:0]   d_err;
`ifdef TLUL_DATA_INTEG_ERR_CNT_EN
  logic         e_clr, d_clr;
  logic [15:0]  e_cnt, d_cnt;
`endif

  int vectors = 0;
  int fails   = 0;
  logic [38:0] eq[$];
  exp_t        dq[$];
  logic [38:0] e_exp;
  exp_t        d_exp;

  // Data-bit participation of each check bit in the Hsiao (39,32) code.
  logic [31:0] hm [7] = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
                          32'hC2C1323B, 32'h2DCC624C, 32'h98505586};

  tlul_data_integ_pipe #(.NumLanes(1), .Mode(0), .Depth(1)) u_enc (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(e_valid), .ready_o(e_ready), .data_i(e_din),
    .valid_o(e_vo), .ready_i(e_ri), .data_o(e_dout), .err_o(e_err)
`ifdef TLUL_DATA_INTEG_ERR_CNT_EN
    , .err_cnt_clr_i(e_clr), .err_cnt_o(e_cnt)
`endif
  );

  tlul_data_integ_pipe #(.NumLanes(4), .Mode(1), .Depth(2)) u_dec (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(d_valid), .ready_o(d_ready), .data_i(d_din),
    .valid_o(d_vo), .ready_i(d_ri), .data_o(d_dout), .err_o(d_err)
`ifdef TLUL_DATA_INTEG_ERR_CNT_EN
    , .err_cnt_clr_i(d_clr), .err_cnt_o(d_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [38:0] m_enc(input logic [31:0] d);
    logic [38:0] w;
    w = {7'h00, d};
    for (int i = 0; i < 7; i++) w[32+i] = ^(d & hm[i]);
    return w ^ 39'h2A00000000;
  endfunction

  // Decode by search: a valid codeword, one flip away from one, or neither.
  function automatic void m_dec(input logic [38:0] w, output logic [31:0] d,
                                output logic [1:0] e);
    logic [38:0] f;
    logic [38:0] one;
    one = 39'd1;
    d = w[31:0];
    e = 2'b10;
    if (m_enc(w[31:0]) == w) begin
      e = 2'b00;
    end else begin
      for (int j = 0; j < 39; j++) begin
        f = w ^ (one << j);
        if (m_enc(f[31:0]) == f) begin
          d = f[31:0];
          e = 2'b01;
        end
      end
    end
  endfunction

  function automatic exp_t m_dec4(input logic [155:0] w);
    exp_t        r;
    logic [31:0] d;
    logic [1:0]  e;
    for (int k = 0; k < 4; k++) begin
      m_dec(w[k*39 +: 39], d, e);
      r.data[k*32 +: 32] = d;
      r.err[2*k +: 2]    = e;
    end
    return r;
  endfunction

  function automatic logic [38:0] mk_word(input logic [31:0] d, input int nflip);
    logic [38:0] w;
    int          j1, j2;
    w  = m_enc(d);
    j1 = $urandom_range(0, 38);
    j2 = (j1 + 1 + $urandom_range(0, 37)) % 39;
    if (nflip >= 1) w[j1] = ~w[j1];
    if (nflip >= 2) w[j2] = ~w[j2];
    return w;
  endfunction

  function automatic logic [155:0] rand_dec_beat();
    logic [155:0] b;
    int           r;
    for (int k = 0; k < 4; k++) begin
      r = $urandom_range(0, 5);
      b[k*39 +: 39] = mk_word($urandom, (r < 3) ? 0 : ((r < 5) ? 1 : 2));
    end
    return b;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic enc_push(input logic [31:0] d);
    int n;
    n = 0;
    e_valid = 1'b1;
    e_din   = d;
    @(negedge clk);
    while (!e_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!e_ready) chk("enc_push_timeout", 128'(e_ready), 128'd1);
    @(posedge clk);
    #1;
    e_valid = 1'b0;
    e_din   = $urandom;
  endtask

  task automatic dec_push(input logic [155:0] w);
    int n;
    n = 0;
    d_valid = 1'b1;
    d_din   = w;
    @(negedge clk);
    while (!d_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!d_ready) chk("dec_push_timeout", 128'(d_ready), 128'd1);
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    d_din   = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // Monitor: pop and compare on every downstream handshake, then log new acceptances.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (e_vo && e_ri) begin
        vectors++;
        if (eq.size() == 0) begin
          fails++;
          $display("FAIL enc_unexpected: got data %0h, required no beat", e_dout);
        end else begin
          e_exp = eq.pop_front();
          if (e_dout !== e_exp || e_err !== 2'b00) begin
            fails++;
            $display("FAIL enc_beat: got %0h err %0h, required %0h err 0", e_dout, e_err, e_exp);
          end
        end
      end
      if (e_valid && e_ready) eq.push_back(m_enc(e_din));
      if (d_vo && d_ri) begin
        vectors++;
        if (dq.size() == 0) begin
          fails++;
          $display("FAIL dec_unexpected: got data %0h, required no beat", d_dout);
        end else begin
          d_exp = dq.pop_front();
          if (d_dout !== d_exp.data || d_err !== d_exp.err) begin
            fails++;
            $display("FAIL dec_beat: got %0h err %0h, required %0h err %0h",
                     d_dout, d_err, d_exp.data, d_exp.err);
          end
        end
      end
      if (d_valid && d_ready) dq.push_back(m_dec4(d_din));
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [38:0]  w0;
    logic [31:0]  l [4];
    logic [155:0] b;
    int           n;
    clk = 1'b0; rst_ni = 1'b1;
    e_valid = 1'b0; e_din = '0; e_ri = 1'b0;
    d_valid = 1'b0; d_din = '0; d_ri = 1'b0;
`ifdef TLUL_DATA_INTEG_ERR_CNT_EN
    e_clr = 1'b0; d_clr = 1'b0;
`endif
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_enc_valid", 128'(e_vo), 128'd0);
    chk("rst_dec_valid", 128'(d_vo), 128'd0);
    chk("rst_dec_data", d_dout, 128'd0);
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    chk("rel_enc_ready", 128'(e_ready), 128'd1);
    chk("rel_dec_ready", 128'(d_ready), 128'd1);
    chk("rel_enc_err", 128'(e_err), 128'd0);
`ifdef TLUL_DATA_INTEG_ERR_CNT_EN
    chk("rel_cnt", 128'(d_cnt), 128'd0);
`endif

    // Encoder: zero word, one-cycle latency.
    e_ri = 1'b1; d_ri = 1'b1;
    @(posedge clk); #1;
    enc_push(32'h0);
    @(negedge clk);
    chk("enc_zero_valid", 128'(e_vo), 128'd1);
    chk("enc_zero_data", 128'(e_dout), 128'h2A00000000);
    chk("enc_zero_err", 128'(e_err), 128'd0);
    enc_push(32'hFFFF_FFFF);
    enc_push(32'h1234_5678);

    // Checker: single then double error in lane 0 around the zero codeword.
    for (int k = 0; k < 4; k++) l[k] = $urandom;
    w0 = 39'h2A00000000;
    w0[5] = ~w0[5];
    dec_push({m_enc(l[3]), m_enc(l[2]), m_enc(l[1]), w0});
    @(negedge clk);
    chk("dec_single_err", 128'(d_err[1:0]), 128'd1);
    chk("dec_single_data", 128'(d_dout[31:0]), 128'd0);
    w0[6] = ~w0[6];
    dec_push({m_enc(l[3]), m_enc(l[2]), m_enc(l[1]), w0});
    @(negedge clk);
    chk("dec_double_err", 128'(d_err[1:0]), 128'd2);
    b = {m_enc(l[3]), mk_word(l[2], 1), m_enc(l[1]), m_enc(l[0])};
    dec_push(b);
    @(negedge clk);
    chk("dec_lane2_err", 128'(d_err), 128'h10);
    chk("dec_lane2_data", d_dout, {l[3], l[2], l[1], l[0]});

    // Fill a Depth-2 buffer with backpressure, then release.
    repeat (3) @(posedge clk);
    #1 d_ri = 1'b0;
    dec_push(rand_dec_beat());
    dec_push(rand_dec_beat());
    d_valid = 1'b1;
    d_din   = rand_dec_beat();
    @(negedge clk);
    chk("full_ready_low", 128'(d_ready), 128'd0);
    @(posedge clk); #1 d_ri = 1'b1;
    @(negedge clk);
    chk("full_ready_low_ri", 128'(d_ready), 128'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_pop", 128'(d_ready), 128'd1);
    chk("valid_after_pop", 128'(d_vo), 128'd1);
    @(posedge clk); #1 d_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Randomised traffic with random backpressure and idle gaps.
    fork
      begin
        repeat (150) begin
          enc_push($urandom);
          n = $urandom_range(0, 2);
          repeat (n) begin @(posedge clk); #1; end
        end
      end
      begin
        repeat (150) begin
          dec_push(rand_dec_beat());
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
      end
      begin
        repeat (600) begin
          @(posedge clk); #1;
          e_ri = 1'($urandom_range(0, 1));
          d_ri = ($urandom_range(0, 3) != 0);
        end
        e_ri = 1'b1;
        d_ri = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Reset with two beats buffered: nothing stale may emerge afterwards.
    d_ri = 1'b0;
    dec_push(rand_dec_beat());
    dec_push(rand_dec_beat());
    @(posedge clk); #3 rst_ni = 1'b0;
    #1;
    chk("inflight_rst_valid", 128'(d_vo), 128'd0);
    chk("inflight_rst_data", d_dout, 128'd0);
    chk("inflight_rst_err", 128'(d_err), 128'd0);
    eq.delete();
    dq.delete();
    d_ri = 1'b1;
    @(posedge clk); #1 rst_ni = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_valid", 128'(d_vo), 128'd0);
    dec_push(rand_dec_beat());
    enc_push($urandom);
    repeat (3) @(posedge clk);
    #1;

`ifdef TLUL_DATA_INTEG_ERR_CNT_EN
    d_clr = 1'b1;
    @(posedge clk); #1 d_clr = 1'b0;
    for (int i = 0; i < 3; i++) dec_push({m_enc($urandom), m_enc($urandom), m_enc($urandom),
                                          mk_word($urandom, 1)});
    dec_push({m_enc($urandom), m_enc($urandom), m_enc($urandom), m_enc($urandom)});
    repeat (2) @(posedge clk);
    #1;
    chk("cnt_three", 128'(d_cnt), 128'd3);
    d_clr = 1'b1;
    dec_push({m_enc($urandom), mk_word($urandom, 2), m_enc($urandom), m_enc($urandom)});
    d_clr = 1'b0;
    chk("cnt_clr_prio", 128'(d_cnt), 128'd0);
    d_valid = 1'b1;
    d_din   = {m_enc($urandom), m_enc($urandom), mk_word($urandom, 1), m_enc($urandom)};
    repeat (65540) @(posedge clk);
    #1 d_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("cnt_saturate", 128'(d_cnt), 128'hFFFF);
    chk("enc_cnt_zero", 128'(e_cnt), 128'd0);
`endif

    n = 0;
    while ((eq.size() != 0 || dq.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_enc", 128'(eq.size()), 128'd0);
    chk("drain_dec", 128'(dq.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/tlul_data_integ_pipe.md
TLUL_DATA_INTEG_PIPE -- requirements
Module: tlul_data_integ_pipe

Interface
REQ-001 SHALL have parameter NumLanes, default 1, number of independent 32-bit data lanes (legal 1..8).
REQ-002 SHALL have parameter Mode, default 0, selecting 0 = encode (32->39 per lane) or 1 = check/correct (39->32 per lane).
REQ-003 SHALL have parameter Depth, default 2, output buffer entries (legal 1..4).
REQ-004 SHALL define InW = 32 and OutW = 39 when Mode = 0, and InW = 39 and OutW = 32 when Mode = 1.
REQ-005 SHALL have port clk_i, input, 1, the single clock; rising edge.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port valid_i, input, 1, upstream beat valid.
REQ-008 SHALL have port ready_o, output, 1, beat accepted when valid_i && ready_o.
REQ-009 SHALL have port data_i, input, NumLanes*InW, lane k at bits [k*InW +: InW].
REQ-010 SHALL have port valid_o, output, 1, downstream beat valid.
REQ-011 SHALL have port ready_i, input, 1, downstream accepts when valid_o && ready_i.
REQ-012 SHALL have port data_o, output, NumLanes*OutW, lane k at bits [k*OutW +: OutW].
REQ-013 SHALL have port err_o, output, NumLanes*2, per lane {double_err, single_err}, aligned with data_o.
REQ-014 SHALL have port err_cnt_clr_i, input, 1, synchronous clear of err_cnt_o; present only with TLUL_DATA_INTEG_ERR_CNT_EN.
REQ-015 SHALL have port err_cnt_o, output, 16, saturating error-beat counter; present only with TLUL_DATA_INTEG_ERR_CNT_EN.

Function
REQ-016 SHALL, in Mode 0, encode each lane with the inverted Hsiao (39,32) SECDED code used by prim_secded_inv_39_32_enc; bits [38:32] are check bits.
REQ-017 SHALL, in Mode 1, decode each lane with prim_secded_inv_39_32_dec; data_o lane = corrected data; err_o lane = decoder {double, single}.
REQ-018 SHALL drive err_o to all-zero in Mode 0.
REQ-019 SHALL compute encode/decode combinationally on data_i and store the result in the buffer on acceptance.
REQ-020 SHALL provide latency of exactly one cycle: a beat accepted at edge N appears on valid_o/data_o/err_o after edge N when the buffer was empty.
REQ-021 SHALL drive ready_o = (occupancy < Depth), with no combinational path from ready_i to ready_o.
REQ-022 SHALL, when full, hold ready_o low even if ready_i is high; the pop frees space for the next cycle.
REQ-023 SHALL, on simultaneous push and pop, leave occupancy unchanged and preserve FIFO order.
REQ-024 SHALL drive valid_o = (occupancy != 0); data_o/err_o show the oldest entry and remain stable while valid_o && !ready_i.
REQ-025 SHALL wrap read/write pointers modulo Depth; when Depth = 1, the buffer behaves as a single full/empty register.
REQ-026 SHALL ignore data_i whenever valid_i is low or ready_o is low.

Reset
REQ-027 SHALL, on rst_ni low, asynchronously empty the buffer: valid_o = 0, ready_o = 1 after release, data_o = 0, err_o = 0, err_cnt_o = 0.
REQ-028 SHALL discard buffered beats that are in flight when reset is asserted; no beat SHALL emerge after release unless it is newly accepted.

Configuration
REQ-029 SHALL, with macro TLUL_DATA_INTEG_ERR_CNT_EN defined, increment err_cnt_o by 1 for every accepted beat in which any lane has single or double error, saturating at 16'hFFFF.
REQ-030 SHALL, with macro TLUL_DATA_INTEG_ERR_CNT_EN defined, give err_cnt_clr_i priority over an increment in the same cycle, leaving the result 0.
REQ-031 SHALL, without TLUL_DATA_INTEG_ERR_CNT_EN, omit err_cnt_clr_i, err_cnt_o and the counter logic; all other behaviour is identical.

Verification
REQ-032 SHALL cover: Mode 0, NumLanes=1, push data 32'h0 with ready_i=1 -> next cycle valid_o=1, data_o=39'h2A00000000, err_o=0.
REQ-033 SHALL cover: Mode 1, push the 39'h2A00000000 codeword with bit 5 flipped -> data_o=32'h0, err_o=2'b01; with bits 5 and 6 flipped -> err_o=2'b10.
REQ-034 SHALL cover: Depth=2, ready_i=0, push 3 beats -> ready_o low after 2 accepted; raise ready_i -> beats out in order, third accepted one cycle after the first pop.
REQ-035 SHALL cover: NumLanes=4 Mode 1, single-bit error only in lane 2 -> err_o=8'b00_01_00_00; other lanes are clean and data is correct.
REQ-036 SHALL cover: with the macro, 3 error beats -> err_cnt_o=3; clear plus an error beat in the same cycle -> 0; the counter preloaded to 16'hFFFF plus an error -> stays 16'hFFFF.
REQ-037 SHALL cover: rst_ni pulsed low with 2 beats buffered -> valid_o=0 immediately, no stale beat after release.
